ram_dma_16x1024: RTL and testbench

RAM_DMA_16X1024 -- requirements
Module: ram_dma_16x1024

---
 rtl/ram_dma_16x1024.sv | 163 ++++++++++++++++
 tb/tb_ram_dma_16x1024.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dma_16x1024.sv
// Single-port RAM DMA engine: copies a block of words from src to dst,
// or fills a dst block with a constant pattern, one word per strobe.
//
// state | meaning
// IDLE  | waiting for start, strobes low
// RD    | read strobe on src+i
// WR    | write strobe on dst+i with the word read in RD
// FILL  | write strobe on dst+i with the latched fill pattern
// DONE  | one-cycle completion pulse
module ram_dma_16x1024 #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output logic              done,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_nxt;
  logic              more;
  logic [DATA_W-1:0] din_q;

  // idx is one bit wider than the address so a 1024-word transfer can
  // terminate; the address sums simply drop the carry to wrap.
  assign idx_nxt = idx + 1'b1;
  assign more    = (idx_nxt < len_q);

  // The RAM's registered read data only arrives during WR, so the copy
  // path bypasses the output register while writing.
  assign ram_din = (state == WR) ? ram_dout : din_q;

  // Sequencer with registered strobes, address and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      din_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ram_read_en  <= 1'b0;
      ram_write_en <= 1'b0;
      ram_addr     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= len;
            idx   <= '0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
              din_q <= '0;
            end else if (mode) begin
              state        <= FILL;
              busy         <= 1'b1;
              ram_write_en <= 1'b1;
              ram_addr     <= dst_addr;
              din_q        <= fill_data;
            end else begin
              state       <= RD;
              busy        <= 1'b1;
              ram_read_en <= 1'b1;
              ram_addr    <= src_addr;
              din_q       <= '0;
            end
          end
        end
        RD: begin
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
          end else begin
            state        <= WR;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b1;
            ram_addr     <= dst_q + idx[ADDR_W-1:0];
          end
        end
        WR: begin
          idx <= idx_nxt;
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            ram_read_en  <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
          end else if (more) begin
            state        <= RD;
            ram_read_en  <= 1'b1;
            ram_write_en <= 1'b0;
            ram_addr     <= src_q + idx_nxt[ADDR_W-1:0];
          end else begin
            state        <= DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
          end
        end
        FILL: begin
          idx <= idx_nxt;
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
            din_q        <= '0;
          end else if (more) begin
            ram_addr <= dst_q + idx_nxt[ADDR_W-1:0];
          end else begin
            state        <= DONE;
            done         <= 1'b1;
            busy         <= 1'b0;
            ram_write_en <= 1'b0;
            ram_addr     <= '0;
            din_q        <= '0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          ram_read_en  <= 1'b0;
          ram_write_en <= 1'b0;
          ram_addr     <= '0;
          din_q        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dma_16x1024.sv
// Directed bench for ram_dma_16x1024 with a behavioural 1024x16 RAM
// (one-cycle registered read) attached to the DMA port.
module tb_ram_dma_16x1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        mode = 1'b0;
  logic [9:0]  src_addr = '0;
  logic [9:0]  dst_addr = '0;
  logic [10:0] len = '0;
  logic [15:0] fill_data = '0;
  logic        busy;
  logic        done;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [9:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout = '0;

  logic [15:0] mem [1024];

  int n_vec = 0;
  int n_err = 0;
  int both_cnt = 0;

  int lat, rd_n, wr_n, alt_err, busy_n, post;
  int done_n, wn, nz;

  ram_dma_16x1024 dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .fill_data    (fill_data),
    .busy         (busy),
    .done         (done),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr] <= ram_din;
    if (ram_read_en)  ram_dout <= mem[ram_addr];
  end

  // strobes must never overlap
  always @(negedge clk) begin
    if (ram_read_en && ram_write_en) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is presented immediately and sampled on
  // the next posedge. Ends at a negedge two cycles after done.
  task run_xfer(input logic m, input logic [9:0] s, input logic [9:0] d,
                input logic [10:0] l, input logic [15:0] f,
                input logic abort_too, input logic poke, input int budget);
    int last;
    mode = m; src_addr = s; dst_addr = d; len = l; fill_data = f;
    start = 1'b1; abort = abort_too;
    @(posedge clk);
    lat = -1; rd_n = 0; wr_n = 0; alt_err = 0; busy_n = 0; post = 0; last = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (busy) busy_n++;
      if (ram_read_en) begin
        if (last == 1) alt_err++;
        last = 1; rd_n++;
      end
      if (ram_write_en) begin
        if (!m && last != 1) alt_err++;
        last = 2; wr_n++;
      end
      if (done) begin
        lat = c;
        if (poke) begin start = 1'b1; mode = 1'b1; len = 11'd1; end
        break;
      end
      if (poke && (c % 3 == 0)) begin start = 1'b1; mode = ~m; len = 11'd1; end
    end
    @(negedge clk);
    start = 1'b0;
    post = post + int'(done) + int'(busy) + int'(ram_write_en) + int'(ram_read_en);
    @(negedge clk);
    post = post + int'(done) + int'(busy) + int'(ram_write_en) + int'(ram_read_en);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] <= 16'h0000;

    // reset, with start and abort also high
    start = 1'b1; abort = 1'b1; len = 11'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", ram_read_en, 0);
    chk("rst_wr", ram_write_en, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);

    // abort in IDLE is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);

    // copy 10..13 -> 100..103
    mem[10] <= 16'hAAAA; mem[11] <= 16'hBBBB; mem[12] <= 16'hCCCC; mem[13] <= 16'hDDDD;
    @(negedge clk);
    run_xfer(1'b0, 10'd10, 10'd100, 11'd4, 16'h0, 1'b0, 1'b0, 40);
    chk("copy_lat", lat, 9);
    chk("copy_rd", rd_n, 4);
    chk("copy_wr", wr_n, 4);
    chk("copy_alt", alt_err, 0);
    chk("copy_busy", busy_n, 8);
    chk("copy_post", post, 0);
    chk("copy_m100", mem[100], 16'hAAAA);
    chk("copy_m101", mem[101], 16'hBBBB);
    chk("copy_m102", mem[102], 16'hCCCC);
    chk("copy_m103", mem[103], 16'hDDDD);
    chk("copy_m104", mem[104], 16'h0000);

    // fill with address wrap
    mem[2] <= 16'h1234;
    @(negedge clk);
    run_xfer(1'b1, 10'd0, 10'd1022, 11'd4, 16'hBEEF, 1'b0, 1'b0, 40);
    chk("fill_lat", lat, 5);
    chk("fill_rd", rd_n, 0);
    chk("fill_wr", wr_n, 4);
    chk("fill_m1022", mem[1022], 16'hBEEF);
    chk("fill_m1023", mem[1023], 16'hBEEF);
    chk("fill_m0", mem[0], 16'hBEEF);
    chk("fill_m1", mem[1], 16'hBEEF);
    chk("fill_m2", mem[2], 16'h1234);
    chk("fill_post", post, 0);

    // len = 0
    run_xfer(1'b0, 10'd5, 10'd6, 11'd0, 16'h0, 1'b0, 1'b0, 10);
    chk("len0_lat", lat, 1);
    chk("len0_strobes", rd_n + wr_n, 0);
    chk("len0_busy", busy_n, 0);
    chk("len0_post", post, 0);

    // abort in the third WR of an 8-word copy
    for (int k = 0; k < 8; k++) begin
      mem[200 + k] <= 16'h2000 + 16'(k);
      mem[300 + k] <= 16'h0000;
    end
    @(negedge clk);
    mode = 1'b0; src_addr = 10'd200; dst_addr = 10'd300; len = 11'd8;
    start = 1'b1;
    @(posedge clk);
    done_n = 0; wn = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_n++;
      if (ram_write_en) wn++;
      if (wn == 3) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        break;
      end
    end
    chk("abort_wn", wn, 3);
    chk("abort_state", {done, busy, ram_read_en, ram_write_en}, 0);
    nz = 0;
    for (int k = 0; k < 8; k++) if (mem[300 + k] != 16'h0000) nz++;
    chk("abort_words", nz, 3);
    chk("abort_m302", mem[302], 16'h2002);
    chk("abort_m303", mem[303], 16'h0000);
    chk("abort_nodone", done_n, 0);
    run_xfer(1'b1, 10'd0, 10'd500, 11'd1, 16'h5555, 1'b0, 1'b0, 10);
    chk("after_abort_lat", lat, 2);
    chk("after_abort_m500", mem[500], 16'h5555);

    // reset during FILL with i=2 (rst also overrides a simultaneous start)
    mode = 1'b1; dst_addr = 10'd600; len = 11'd6; fill_data = 16'h7777;
    start = 1'b1;
    @(posedge clk);
    done_n = 0; wn = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_n++;
      if (ram_write_en) wn++;
      if (wn == 3) begin
        chk("rstfill_addr", ram_addr, 602);
        rst = 1'b1; start = 1'b1; len = 11'd0;
        @(negedge clk);
        chk("rstfill_out", {busy, done, ram_read_en, ram_write_en, 6'(ram_addr), ram_din}, 0);
        rst = 1'b0; start = 1'b0;
        break;
      end
    end
    @(negedge clk);
    chk("rstfill_idle", {busy, done}, 0);
    chk("rstfill_nodone", done_n, 0);
    run_xfer(1'b1, 10'd0, 10'd610, 11'd2, 16'h1357, 1'b0, 1'b0, 10);
    chk("after_rst_lat", lat, 3);
    chk("after_rst_m610", mem[610], 16'h1357);
    chk("after_rst_m611", mem[611], 16'h1357);

    // overlapping copy, start+abort together, start pokes while busy/done
    mem[0] <= 16'h0005; mem[1] <= 16'h0009; mem[2] <= 16'h0009;
    mem[3] <= 16'h0009; mem[4] <= 16'h0009;
    @(negedge clk);
    run_xfer(1'b0, 10'd0, 10'd1, 11'd3, 16'h0, 1'b1, 1'b1, 40);
    chk("ovl_lat", lat, 7);
    chk("ovl_wr", wr_n, 3);
    chk("ovl_m1", mem[1], 16'h0005);
    chk("ovl_m2", mem[2], 16'h0005);
    chk("ovl_m3", mem[3], 16'h0005);
    chk("ovl_m4", mem[4], 16'h0009);
    chk("ovl_post", post, 0);

    chk("strobe_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
